// File: rtl/demux_dist4.sv
// demux_dist4: 1-to-4 valid/ready distributor with per-channel one-entry
// buffers, sel or round-robin steering, and a saturating stall counter.
module demux_dist4 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       sel,
    input  logic             mode,
    output logic [WIDTH-1:0] out_data0,
    output logic [WIDTH-1:0] out_data1,
    output logic [WIDTH-1:0] out_data2,
    output logic [WIDTH-1:0] out_data3,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [1:0]       rr_ptr,
    output logic [7:0]       drop_cnt
);

    logic [WIDTH-1:0] data_q [4];
    logic [3:0]       full_q;
    logic [1:0]       target;
    logic             accept;
    logic             stall;

    assign target   = mode ? rr_ptr : sel;
    // A full buffer still accepts when its consumer drains it this cycle.
    assign in_ready = !full_q[target] || out_ready[target];
    assign accept   = in_valid && in_ready;
    assign stall    = in_valid && !in_ready;

    assign out_valid = full_q;
    assign out_data0 = data_q[0];
    assign out_data1 = data_q[1];
    assign out_data2 = data_q[2];
    assign out_data3 = data_q[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q   <= '0;
            rr_ptr   <= '0;
            drop_cnt <= '0;
            for (int k = 0; k < 4; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (accept && target == 2'(k)) begin
                    full_q[k] <= 1'b1;
                    data_q[k] <= in_data;
                end else if (full_q[k] && out_ready[k]) begin
                    full_q[k] <= 1'b0;
                end
            end
            if (accept && mode) begin
                rr_ptr <= rr_ptr + 2'd1;
            end
            if (stall && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_demux_dist4.sv
// Self-checking bench for demux_dist4: directed scenarios plus random
// traffic compared against an array-based reference model.
module tb_demux_dist4;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       sel;
    logic             mode;
    logic [WIDTH-1:0] out_data0, out_data1, out_data2, out_data3;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [1:0]       rr_ptr;
    logic [7:0]       drop_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit         m_full [4];
    logic [7:0] m_data [4];
    int         m_ptr;
    int         m_drop;

    demux_dist4 #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .mode      (mode),
        .out_data0 (out_data0),
        .out_data1 (out_data1),
        .out_data2 (out_data2),
        .out_data3 (out_data3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rr_ptr    (rr_ptr),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_full[k] = 0;
            m_data[k] = '0;
        end
        m_ptr  = 0;
        m_drop = 0;
    endtask

    function automatic int m_target();
        return mode ? m_ptr : int'(sel);
    endfunction

    function automatic bit m_ready();
        int t;
        t = m_target();
        return !m_full[t] || out_ready[t];
    endfunction

    task automatic model_clock();
        int t;
        bit rdy;
        t   = m_target();
        rdy = m_ready();
        for (int k = 0; k < 4; k++) begin
            if (m_full[k] && out_ready[k]) m_full[k] = 0;
        end
        if (in_valid && rdy) begin
            m_full[t] = 1;
            m_data[t] = in_data;
            if (mode) m_ptr = (m_ptr + 1) % 4;
        end
        if (in_valid && !rdy && m_drop < 255) m_drop++;
    endtask

    task automatic check_all(input string tag);
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = m_full[k];
        chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
        chk({tag, ".out_data0"}, 32'(out_data0), 32'(m_data[0]));
        chk({tag, ".out_data1"}, 32'(out_data1), 32'(m_data[1]));
        chk({tag, ".out_data2"}, 32'(out_data2), 32'(m_data[2]));
        chk({tag, ".out_data3"}, 32'(out_data3), 32'(m_data[3]));
        chk({tag, ".rr_ptr"}, 32'(rr_ptr), 32'(m_ptr));
        chk({tag, ".drop_cnt"}, 32'(drop_cnt), 32'(m_drop));
    endtask

    // One clock cycle: drive at negedge, check in_ready, clock, check state.
    task automatic step(input string tag, input logic [7:0] d, input logic v,
                        input logic [1:0] s, input logic m,
                        input logic [3:0] r);
        @(negedge clk);
        in_data   = d;
        in_valid  = v;
        sel       = s;
        mode      = m;
        out_ready = r;
        #1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(m_ready()));
        @(posedge clk);
        model_clock();
        #1;
        check_all(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = 8'h77;
        in_valid  = 1'b1;
        sel       = 2'd1;
        mode      = 1'b0;
        out_ready = 4'b0000;
        model_reset();

        // reset state, and no transfer accepted while held in reset
        #1;
        check_all("rst");
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        chk("rst_hold.out_valid", 32'(out_valid), 32'd0);
        chk("rst_hold.drop_cnt", 32'(drop_cnt), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b1;

        // single steered word to channel 2
        step("sel2", 8'hA5, 1, 2'd2, 0, 4'b0000);
        chk("sel2.valid_lit", 32'(out_valid), 32'b0100);
        chk("sel2.data2_lit", 32'(out_data2), 32'hA5);

        // stall on full channel 2, then drain-and-refill same cycle
        step("stall1", 8'h5A, 1, 2'd2, 0, 4'b0000);
        chk("stall1.drop_lit", 32'(drop_cnt), 32'd1);
        step("stall2", 8'h5A, 1, 2'd2, 0, 4'b0000);
        chk("stall2.drop_lit", 32'(drop_cnt), 32'd2);
        step("refill", 8'h5A, 1, 2'd2, 0, 4'b0100);
        chk("refill.valid_lit", 32'(out_valid), 32'b0100);
        chk("refill.data2_lit", 32'(out_data2), 32'h5A);
        step("drain", 8'h00, 0, 2'd0, 0, 4'b1111);

        // round-robin: five back-to-back words
        for (int i = 0; i < 5; i++) begin
            step("rr5", 8'(8'h10 + i), 1, 2'd3, 1, 4'b1111);
            chk("rr5.valid_lit", 32'(out_valid), 32'(4'b0001 << (i % 4)));
        end
        chk("rr5.data0_lit", 32'(out_data0), 32'h14);
        chk("rr5.data3_lit", 32'(out_data3), 32'h13);
        chk("rr5.ptr_lit", 32'(rr_ptr), 32'd1);

        // pointer frozen while steering by sel
        step("rr_one", 8'h20, 1, 2'd0, 1, 4'b1111);
        step("m0a", 8'h21, 1, 2'd0, 0, 4'b1111);
        step("m0b", 8'h22, 1, 2'd1, 0, 4'b1111);
        step("m0c", 8'h23, 1, 2'd3, 0, 4'b1111);
        chk("m0.ptr_lit", 32'(rr_ptr), 32'd2);
        step("drain2", 8'h00, 0, 2'd0, 0, 4'b1111);

        // drop counter saturation
        step("fill0", 8'h33, 1, 2'd0, 0, 4'b0000);
        for (int i = 0; i < 300; i++) begin
            step("sat", 8'h44, 1, 2'd0, 0, 4'b0000);
        end
        chk("sat.drop_lit", 32'(drop_cnt), 32'hFF);
        step("drain3", 8'h00, 0, 2'd0, 0, 4'b1111);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            step("rand", 8'($urandom), $urandom_range(0, 3) != 0,
                 2'($urandom), 1'($urandom), 4'($urandom));
        end

        // async reset mid-cycle with channels 0 and 3 full
        step("drain4", 8'h00, 0, 2'd0, 0, 4'b1111);
        step("rr_pre", 8'h61, 1, 2'd0, 1, 4'b1111);
        step("fill_0", 8'h62, 1, 2'd0, 0, 4'b1111);
        step("fill_3", 8'h63, 1, 2'd3, 0, 4'b0000);
        chk("pre_rst.full03", 32'(out_valid & 4'b1001), 32'b1001);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        chk("async_rst.valid_lit", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        step("post_rst", 8'h7E, 1, 2'd1, 0, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_dist4.md
DEMUX_DIST4 -- requirements
Module: demux_dist4

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of every data port.
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port in_data, input, WIDTH, word to distribute.
REQ-005 SHALL have port in_valid, input, 1, in_data valid this cycle.
REQ-006 SHALL have port in_ready, output, 1, block accepts in_data this cycle.
REQ-007 SHALL have port sel, input, 2, target channel when mode=0.
REQ-008 SHALL have port mode, input, 1, 0 = steered by sel, 1 = round-robin pointer.
REQ-009 SHALL have ports out_data0..out_data3, output, WIDTH each, per-channel held word.
REQ-010 SHALL have port out_valid, output, 4, bit k = channel k holds a word.
REQ-011 SHALL have port out_ready, input, 4, bit k = channel k consumer takes word this cycle.
REQ-012 SHALL have port rr_ptr, output, 2, current round-robin pointer.
REQ-013 SHALL have port drop_cnt, output, 8, saturating count of cycles with in_valid=1 and in_ready=0.

Function
REQ-014 SHALL compute target t = sel when mode=0, t = rr_ptr when mode=1.
REQ-015 SHALL hold one-entry buffer per channel: data register plus full flag; out_valid[k] = full flag k; out_data k = data register k.
REQ-016 SHALL drive in_ready = !out_valid[t] | out_ready[t] (combinational; empty or draining same cycle).
REQ-017 SHALL accept on in_valid & in_ready; accepted word written to buffer t, full flag t set next cycle.
REQ-018 SHALL clear full flag k on out_valid[k] & out_ready[k] unless same channel is written same cycle, in which case flag stays 1 and data takes new word (no bubble, no loss).
REQ-019 SHALL leave out_data k unchanged when not written; no other channel affected by a transfer.
REQ-020 SHALL advance rr_ptr by 1 modulo 4 (3 -> 0 wrap) only on accepted transfer while mode=1; hold otherwise, including while mode=0.
REQ-021 SHALL allow sel/mode changes any cycle; target evaluated from current-cycle values only.
REQ-022 SHALL increment drop_cnt on each stall cycle (in_valid=1, in_ready=0), saturating at 255.
REQ-023 SHALL have accept-to-out_valid latency of exactly 1 cycle; drain independent per channel.
REQ-024 SHALL ignore out_ready[k] while out_valid[k]=0.

Reset
REQ-025 SHALL, while rst_n=0, asynchronously force all full flags 0, out_valid=4'b0000, all out_data=0, rr_ptr=0, drop_cnt=0.
REQ-026 SHALL discard buffered words on reset mid-operation; first rising edge after rst_n rises is a normal cycle.
REQ-027 SHALL drive in_ready per REQ-016 during reset (all empty -> in_ready=1), but no transfer is accepted while rst_n=0.

Verification
REQ-028 SHALL verify: reset, mode=0, sel=2, in_data=8'hA5, in_valid one cycle, out_ready=0 -> next cycle out_valid=4'b0100, out_data2=8'hA5, others 0.
REQ-029 SHALL verify: channel 2 full, out_ready=0, second word sel=2 -> in_ready=0, drop_cnt increments per stalled cycle; raising out_ready[2] same cycle -> in_ready=1, new word replaces old, out_valid[2] stays 1.
REQ-030 SHALL verify: mode=1, all out_ready=1, five back-to-back words 8'h10..8'h14 -> channels 0,1,2,3,0 receive them in order, rr_ptr ends at 1.
REQ-031 SHALL verify: mode=1, word accepted, then mode=0 for three accepts -> rr_ptr unchanged during mode=0.
REQ-032 SHALL verify: 300 stall cycles -> drop_cnt saturates at 8'hFF.
REQ-033 SHALL verify: rst_n pulsed low mid-cycle with channels 0 and 3 full -> out_valid=0, out_data all 0, rr_ptr=0 immediately, without waiting for clk.
